// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the request/grant signals of the internal 8-bit tristate bus arbiter.
//   req[N]         : per-driver request, level-sensitive
//   lock[N]        : per-driver lock, blocks hold-limit preemption of the owner
//   grant[N]       : registered one-hot (or zero) grant, drives tristate enables
//   owner[OW]      : index of current owner, 0 when nobody owns the bus
//   owner_valid    : |grant
//   bus_idle       : ~|grant
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int N = 4
) ();
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [N-1:0]  grant;
    logic [OW-1:0] owner;
    logic          owner_valid;
    logic          bus_idle;

    modport master (
        output req,
        output lock,
        input  grant,
        input  owner,
        input  owner_valid,
        input  bus_idle
    );

    modport slave (
        input  req,
        input  lock,
        output grant,
        output owner,
        output owner_valid,
        output bus_idle
    );
endinterface

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared internal tristate bus. Grants are
// registered and one-hot so they can drive tristate enables directly, and an
// optional turnaround gap keeps two drivers from ever being enabled together.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : bus_arbiter_if.slave (req/lock in, grant/owner/owner_valid/
//            bus_idle out, all outputs registered)
// Parameters:
//   N          : number of requesters (2..8)
//   TURNAROUND : dead cycles between successive owners (0..3)
//   MAXHOLD    : max consecutive grant cycles under contention, 0 = unlimited
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N          = 4,
    parameter int TURNAROUND = 1,
    parameter int MAXHOLD    = 8
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1);

    localparam logic [HW-1:0] HOLD_MAX  = {HW{1'b1}};
    localparam logic [HW-1:0] HOLD_LIM  = HW'(MAXHOLD);
    localparam logic [1:0]    TURN_INIT = 2'(TURNAROUND);
    localparam logic [OW-1:0] LAST_RST  = OW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    // First requester after 'last', wrapping modulo N.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [OW-1:0] last);
        logic [OW-1:0] w;
        logic          found;
        logic [N-1:0]  rot;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            rot = r >> idx;
            if (!found && rot[0]) begin
                w     = OW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [OW-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    turn_q, turn_d;
    logic          valid_q, valid_d;
    logic          idle_q, idle_d;

    logic          take;
    logic [OW-1:0] win;
    logic          any_req;
    logic          owner_req;
    logic          owner_lock;
    logic          others;
    logic          preempt;
    logic          release_own;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            hold_q  <= '0;
            turn_q  <= '0;
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            valid_q <= valid_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        win        = rr_pick(bus.req, last_q);
        any_req    = |bus.req;
        // grant_q is one-hot while owning, so masking with it selects the owner.
        owner_req  = |(bus.req & grant_q);
        owner_lock = |(bus.lock & grant_q);
        others     = |(bus.req & ~grant_q);
        preempt    = (MAXHOLD != 0) && (hold_q >= HOLD_LIM) && !owner_lock && others;
        release_own = !owner_req || preempt;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWN;
                    take    = 1'b1;
                end
            end
            OWN: begin
                if (release_own) begin
                    if (TURNAROUND != 0) begin
                        state_d = TURN;
                    end else if (any_req) begin
                        // Pointer already sits on the old owner, so a waiting
                        // requester always wins over it.
                        state_d = OWN;
                        take    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TURN: begin
                if (turn_q <= 2'd1) begin
                    if (any_req) begin
                        state_d = OWN;
                        take    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        turn_d  = turn_q;

        if (take) begin
            grant_d = onehot(win);
            owner_d = win;
            last_d  = win;
            hold_d  = HW'(1);
        end else if (state_d != OWN) begin
            grant_d = '0;
            owner_d = '0;
            hold_d  = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
        end

        if (state_q == OWN && state_d == TURN) begin
            turn_d = TURN_INIT;
        end else if (state_q == TURN && turn_q != 2'd0) begin
            turn_d = turn_q - 2'd1;
        end

        valid_d = |grant_d;
        idle_d  = ~|grant_d;
    end

    assign bus.grant       = grant_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = valid_q;
    assign bus.bus_idle    = idle_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
// Two arbiters share clock and reset: A (TURNAROUND=1, MAXHOLD=8) and
// B (TURNAROUND=0, MAXHOLD=0). A behavioural model tracks the owner, how long
// it has held the bus, the remaining dead cycles and the round-robin pointer;
// every cycle both DUTs are compared against it. Directed literal checks pin
// the expected sequences by hand.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if #(.N(N)) ifa ();
    bus_arbiter_if #(.N(N)) ifb ();

    bus_arbiter #(.N(N), .TURNAROUND(1), .MAXHOLD(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    bus_arbiter #(.N(N), .TURNAROUND(0), .MAXHOLD(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: owner (-1 = none), cycles held, dead cycles
    // remaining, last granted index.
    int m_own  [2];
    int m_cnt  [2];
    int m_gap  [2];
    int m_last [2];
    int p_ta   [2] = '{1, 0};
    int p_mh   [2] = '{8, 0};

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        logic [N-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pick(input int i, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last[i] + k) % N;
            if (bit_of(r, idx)) begin
                m_own[i]  = idx;
                m_last[i] = idx;
                m_cnt[i]  = 1;
                return;
            end
        end
    endtask

    task automatic model_step(input int i, input logic [N-1:0] r,
                              input logic [N-1:0] l, input logic rst);
        bit others;
        bit rel;
        if (rst) begin
            m_own[i]  = -1;
            m_cnt[i]  = 0;
            m_gap[i]  = 0;
            m_last[i] = N - 1;
        end else if (m_own[i] >= 0) begin
            others = 0;
            for (int j = 0; j < N; j++)
                if (j != m_own[i] && bit_of(r, j)) others = 1;
            rel = !bit_of(r, m_own[i]) ||
                  (p_mh[i] != 0 && m_cnt[i] >= p_mh[i] && !bit_of(l, m_own[i]) && others);
            if (!rel) begin
                m_cnt[i]++;
            end else begin
                m_own[i] = -1;
                if (p_ta[i] > 0) m_gap[i] = p_ta[i];
                else pick(i, r);
            end
        end else if (m_gap[i] > 1) begin
            m_gap[i]--;
        end else begin
            m_gap[i] = 0;
            pick(i, r);
        end
    endtask

    task automatic cmp(input int i, input logic [N-1:0] g, input logic [1:0] o,
                       input logic v, input logic id);
        logic [N-1:0] eg;
        logic [1:0]   eo;
        string        p;
        p  = (i == 0) ? "A" : "B";
        eg = (m_own[i] >= 0) ? (N'(1) << m_own[i]) : '0;
        eo = (m_own[i] >= 0) ? 2'(m_own[i]) : 2'd0;
        check($sformatf("%s.grant", p), 8'(g), 8'(eg));
        check($sformatf("%s.owner", p), 8'(o), 8'(eo));
        check($sformatf("%s.owner_valid", p), 8'(v), 8'(m_own[i] >= 0));
        check($sformatf("%s.bus_idle", p), 8'(id), 8'(m_own[i] < 0));
        check($sformatf("%s.onehot0", p), 8'($onehot0(g)), 8'd1);
    endtask

    // Per-cycle model compare
    always @(posedge clk) begin
        model_step(0, ifa.req, ifa.lock, reset);
        model_step(1, ifb.req, ifb.lock, reset);
        #1;
        cmp(0, ifa.grant, ifa.owner, ifa.owner_valid, ifa.bus_idle);
        cmp(1, ifb.grant, ifb.owner, ifb.owner_valid, ifb.bus_idle);
    end

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        int           cycles;
    } vec_t;

    vec_t tbl [8] = '{
        '{4'b1001, 4'b0000, 12},
        '{4'b0110, 4'b0100, 14},
        '{4'b0110, 4'b0000, 6},
        '{4'b1111, 4'b1000, 10},
        '{4'b0011, 4'b0000, 20},
        '{4'b0000, 4'b0000, 3},
        '{4'b0101, 4'b0001, 5},
        '{4'b1110, 4'b0000, 25}
    };

    initial begin
        reset    = 1'b1;
        ifa.req  = 4'b1111;
        ifa.lock = 4'b0000;
        ifb.req  = 4'b0000;
        ifb.lock = 4'b0000;

        // Reset held two cycles with all requests high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t1.grant_in_reset", 8'(ifa.grant), 8'h00);
            check("t1.idle_in_reset", 8'(ifa.bus_idle), 8'h01);
        end
        reset = 1'b0;
        @(negedge clk);
        check("t1.first_grant", 8'(ifa.grant), 8'b0001);

        // Full contention: 8 cycles each, one dead cycle between owners
        repeat (7) begin
            @(negedge clk);
            check("t3.hold0", 8'(ifa.grant), 8'b0001);
        end
        @(negedge clk);
        check("t3.gap", 8'(ifa.grant), 8'h00);
        for (int o = 1; o <= 4; o++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                check("t3.rotate", 8'(ifa.grant), 8'(4'b0001 << (o % 4)));
            end
            if (o < 4) begin
                @(negedge clk);
                check("t3.gap", 8'(ifa.grant), 8'h00);
            end
        end

        // Single requester, then drop
        ifa.req = 4'b0000;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        ifa.req = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("t2.grant", 8'(ifa.grant), 8'b0100);
            check("t2.owner", 8'(ifa.owner), 8'd2);
        end
        ifa.req = 4'b0000;
        @(negedge clk);
        check("t2.release", 8'(ifa.grant), 8'h00);
        check("t2.release_idle", 8'(ifa.bus_idle), 8'h01);
        @(negedge clk);
        check("t2.idle", 8'(ifa.owner_valid), 8'h00);

        // Lock blocks preemption, dropping lock releases on next edge
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        ifa.req  = 4'b1010;
        ifa.lock = 4'b0010;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            check("t4.locked", 8'(ifa.grant), 8'b0010);
        end
        ifa.lock = 4'b0000;
        @(negedge clk);
        check("t4.unlock_release", 8'(ifa.grant), 8'h00);
        @(negedge clk);
        check("t4.next_owner", 8'(ifa.grant), 8'b1000);
        check("t4.next_owner_idx", 8'(ifa.owner), 8'd3);

        // Mid-operation reset overrides lock and restores the pointer
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        ifa.req = 4'b0010;
        @(negedge clk);
        check("t5.pre_grant", 8'(ifa.grant), 8'b0010);
        ifa.req  = 4'b1111;
        ifa.lock = 4'b1111;
        reset    = 1'b1;
        @(negedge clk);
        check("t5.reset_drop", 8'(ifa.grant), 8'h00);
        reset    = 1'b0;
        ifa.lock = 4'b0000;
        @(negedge clk);
        check("t5.ptr_reset", 8'(ifa.grant), 8'b0001);

        // Mixed patterns checked by the model only
        for (int t = 0; t < 8; t++) begin
            ifa.req  = tbl[t].req;
            ifa.lock = tbl[t].lock;
            repeat (tbl[t].cycles) @(negedge clk);
        end
        ifa.req  = 4'b0000;
        ifa.lock = 4'b0000;

        // Zero turnaround, unlimited hold on instance B
        ifb.req = 4'b0011;
        @(negedge clk);
        check("t6.first", 8'(ifb.grant), 8'b0001);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t6.unlimited", 8'(ifb.grant), 8'b0001);
        end
        ifb.req = 4'b0010;
        @(negedge clk);
        check("t6.direct_switch", 8'(ifb.grant), 8'b0010);
        check("t6.direct_owner", 8'(ifb.owner), 8'd1);
        ifb.req = 4'b0000;
        @(negedge clk);
        check("t6.drop", 8'(ifb.grant), 8'h00);
        check("t6.idle", 8'(ifb.bus_idle), 8'h01);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared 8-bit internal tristate bus of the hmc-6502 datapath.
- Arbitrates among N bus drivers (register buffers, ALU result, memory data-in).
- Produces one-hot registered grants that drive the tristate enables directly.
- Inserts programmable dead cycles between owners so two drivers are never enabled on the same cycle.

Parameters:
N, 4, number of requesters (2..8)
TURNAROUND, 1, idle cycles with no grant between successive owners (0..3)
MAXHOLD, 8, max consecutive grant cycles while others wait; 0 = unlimited

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  N  request per driver; level-sensitive, held while bus wanted
lock  input  N  per-driver lock; when set on current owner, blocks MAXHOLD preemption
grant  output  N  one-hot or zero registered grant; wire to tristate enable
owner  output  OW  index of current owner (OW = clog2(N)); 0 when no grant
owner_valid  output  1  |grant
bus_idle  output  1  high when no grant (IDLE or TURN state)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All outputs registered; state changes only on posedge clk.
- Reset values:
  - grant=0, owner=0, owner_valid=0, bus_idle=1.
  - state=IDLE, hold_cnt=0, turn_cnt=0.
  - last pointer=N-1, so requester 0 has top priority first.
- Invariant: grant is one-hot or zero every cycle. When TURNAROUND>0, no edge moves grant directly from one owner to another.
- Arbitration function:
  - Winner = first i with req[i]=1, searching i = last+1, last+2, ... modulo N.
  - On grant, last <= winner.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any req is sampled at an edge, the next state is OWN. grant=onehot(winner) and hold_cnt=1.
  - Latency is one edge: req high in cycle t gives grant high from cycle t+1.
- OWN, at each edge:
  - Release if req[owner]=0.
  - Release if MAXHOLD!=0, hold_cnt>=MAXHOLD, lock[owner]=0, and some other req is high.
  - Otherwise stay; hold_cnt increments, saturating at its max (width clog2(MAXHOLD+1), minimum 1).
  - Result: with contention and no lock, grant stays high for exactly MAXHOLD cycles.
  - With lock set, or with no other requester, ownership continues indefinitely.
  - When lock drops with hold_cnt already >= MAXHOLD and others pending, release happens at the next edge.
- Release:
  - grant <= 0.
  - If TURNAROUND>0: go to TURN with turn_cnt=TURNAROUND.
  - If TURNAROUND=0: arbitrate on the same edge. The old owner cannot be re-selected if another req is high, because the pointer already points past it. Grant moves directly to the new owner, or goes to IDLE if there are no requests.
- TURN:
  - turn_cnt decrements each edge.
  - On the edge where turn_cnt==1: arbitrate as in IDLE (go to OWN if any req, else IDLE).
  - Requests that drop during TURN are not granted. Arbitration uses only req sampled at that edge.
- Requests are not latched. A req pulse that is deasserted before its arbitration edge is lost (not an error).
- The owner deasserting req and reasserting it later rejoins round-robin at its normal priority.
- Reset mid-operation: grant drops at the next edge regardless of state or lock; the pointer returns to N-1.
- owner/owner_valid/bus_idle are registered alongside grant and are always consistent with it.

Test Plan:
1. Reset held 2 cycles with req=4'b1111 -> grant=0000, bus_idle=1 throughout reset; first grant=0001 one cycle after reset released.
2. req=0100 raised at cycle 5, dropped at cycle 12 -> grant=0100 in cycles 6..12, grant=0000 in cycle 13 (TURN), then IDLE; owner=2 while granted.
3. req=1111 held constant, lock=0 -> grant sequence 0001,0010,0100,1000,0001 each for exactly 8 cycles, with one zero cycle between each; never two bits set.
4. req=1010 and lock=0010 held 20 cycles -> grant=0010 for 20+ cycles; lock drops at cycle 25 -> grant=0000 next edge, then 1000 after one turnaround cycle.
5. grant=0010 active, reset pulsed 1 cycle with req=1111 -> grant=0000 next cycle; after reset, first grant=0001 (pointer reset), not 0100.
6. TURNAROUND=0, MAXHOLD=0: req=0011 held, then req[0] dropped -> grant switches 0001->0010 on a single edge with no zero cycle; req=0000 -> grant=0000, bus_idle=1.
